// File: rtl/gmii_mac_tx.sv
// MAC-side GMII transmitter: wraps an AXI-stream payload with preamble/SFD,
// optional zero padding, the Ethernet FCS and the inter-frame gap.
module gmii_mac_tx #(
    parameter int ENABLE_PADDING   = 1,
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int IFG              = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic [7:0] gmii_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic       start_packet,
    output logic       error_underflow
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, PAYLOAD, PAD, FCS, IFG_WAIT, DRAIN} state_t;

    localparam logic [6:0] PAD_TARGET = 7'(MIN_FRAME_LENGTH - 4);
    localparam logic [7:0] IFG_LAST   = 8'(IFG - 1);

    state_t      state, state_next;
    logic [7:0]  cnt, cnt_next;
    logic [6:0]  byte_cnt, byte_cnt_next, byte_cnt_inc;
    logic [31:0] crc, crc_next, fcs;
    logic [7:0]  txd_next;
    logic        tx_en_next, tx_er_next, start_next, underflow_next;

    // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // The SFD cycle is already PAYLOAD state, so tready depends on state alone.
    assign s_axis_tready = (state == PAYLOAD) || (state == DRAIN);
    assign byte_cnt_inc  = (byte_cnt == 7'd127) ? byte_cnt : byte_cnt + 7'd1;
    assign fcs           = ~crc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= 8'd0;
            byte_cnt        <= 7'd0;
            crc             <= 32'hFFFFFFFF;
            gmii_txd        <= 8'h00;
            gmii_tx_en      <= 1'b0;
            gmii_tx_er      <= 1'b0;
            start_packet    <= 1'b0;
            error_underflow <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            byte_cnt        <= byte_cnt_next;
            crc             <= crc_next;
            gmii_txd        <= txd_next;
            gmii_tx_en      <= tx_en_next;
            gmii_tx_er      <= tx_er_next;
            start_packet    <= start_next;
            error_underflow <= underflow_next;
        end
    end

    // Next-state logic also computes the GMII values for the following cycle.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        byte_cnt_next  = byte_cnt;
        crc_next       = crc;
        txd_next       = 8'h00;
        tx_en_next     = 1'b0;
        tx_er_next     = 1'b0;
        start_next     = 1'b0;
        underflow_next = 1'b0;
        case (state)
            IDLE: begin
                crc_next      = 32'hFFFFFFFF;
                byte_cnt_next = 7'd0;
                cnt_next      = 8'd0;
                if (s_axis_tvalid) begin
                    txd_next   = 8'h55;
                    tx_en_next = 1'b1;
                    state_next = PREAMBLE;
                end
            end
            PREAMBLE: begin
                tx_en_next = 1'b1;
                if (cnt == 8'd6) begin
                    txd_next   = 8'hD5;
                    start_next = 1'b1;
                    cnt_next   = 8'd0;
                    state_next = PAYLOAD;
                end else begin
                    txd_next = 8'h55;
                    cnt_next = cnt + 8'd1;
                end
            end
            PAYLOAD: begin
                tx_en_next = 1'b1;
                if (s_axis_tvalid) begin
                    txd_next      = s_axis_tdata;
                    crc_next      = crc_byte(crc, s_axis_tdata);
                    byte_cnt_next = byte_cnt_inc;
                    if (s_axis_tlast) begin
                        tx_er_next = s_axis_tuser;
                        if ((ENABLE_PADDING != 0) && (byte_cnt_inc < PAD_TARGET)) begin
                            state_next = PAD;
                        end else begin
                            state_next = FCS;
                        end
                    end
                end else begin
                    tx_er_next     = 1'b1;
                    underflow_next = 1'b1;
                    state_next     = DRAIN;
                end
            end
            PAD: begin
                tx_en_next    = 1'b1;
                crc_next      = crc_byte(crc, 8'h00);
                byte_cnt_next = byte_cnt_inc;
                if (byte_cnt_inc >= PAD_TARGET) begin
                    state_next = FCS;
                end
            end
            FCS: begin
                tx_en_next = 1'b1;
                txd_next   = 8'(fcs >> {cnt[1:0], 3'b000});
                if (cnt == 8'd3) begin
                    cnt_next   = 8'd0;
                    state_next = IFG_WAIT;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            IFG_WAIT: begin
                crc_next      = 32'hFFFFFFFF;
                byte_cnt_next = 7'd0;
                if (cnt == IFG_LAST) begin
                    cnt_next   = 8'd0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            DRAIN: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    cnt_next   = 8'd0;
                    state_next = IFG_WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gmii_mac_tx.sv
// Directed bench for gmii_mac_tx: one unpadded instance, one with default parameters.
module tb_gmii_mac_tx;

    typedef struct {
        int         d;
        int         cyc;
        logic [7:0] txd;
        logic       en, er, sp, uf;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tdata [2];
    logic       tvalid[2], tlast[2], tuser[2], tready[2];
    logic [7:0] txd   [2];
    logic       en[2], er[2], sp[2], uf[2];

    rec_t       lg[$];
    beat_t      beats[$];
    logic [7:0] hb[$], exp_q[$], mdl[$];
    int         hc[$];
    logic       her[$], hsp[$], huf[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    gmii_mac_tx #(.ENABLE_PADDING(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
        .s_axis_tlast(tlast[0]), .s_axis_tuser(tuser[0]),
        .gmii_txd(txd[0]), .gmii_tx_en(en[0]), .gmii_tx_er(er[0]),
        .start_packet(sp[0]), .error_underflow(uf[0])
    );

    gmii_mac_tx dut1 (
        .clk(clk), .rst(rst),
        .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
        .s_axis_tlast(tlast[1]), .s_axis_tuser(tuser[1]),
        .gmii_txd(txd[1]), .gmii_tx_en(en[1]), .gmii_tx_er(er[1]),
        .start_packet(sp[1]), .error_underflow(uf[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            rec_t r;
            r.d = k; r.cyc = cyc; r.txd = txd[k];
            r.en = en[k]; r.er = er[k]; r.sp = sp[k]; r.uf = uf[k];
            lg.push_back(r);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic add_frame(input int n, input logic [7:0] first, input logic user);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data = 8'(first + i);
            b.last = (i == n - 1);
            b.user = user && (i == n - 1);
            beats.push_back(b);
        end
    endtask

    // Presents queued beats on instance d; one optional bubble of stall_len cycles.
    task automatic drive_beats(input int d, input int stall_at, input int stall_len);
        int i = 0;
        int stalled = 0;
        int guard = 0;
        while (i < beats.size() && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (i == stall_at && stalled < stall_len) begin
                tvalid[d] = 1'b0;
                stalled++;
            end else begin
                tvalid[d] = 1'b1;
                tdata[d]  = beats[i].data;
                tlast[d]  = beats[i].last;
                tuser[d]  = beats[i].user;
                if (tready[d]) i++;
            end
        end
        tests++;
        if (i < beats.size()) begin
            fails++;
            $display("[TB] FAIL drive_timeout: accepted %0d beats, required %0d", i, beats.size());
        end
        @(negedge clk);
        tvalid[d] = 1'b0; tlast[d] = 1'b0; tuser[d] = 1'b0;
        beats.delete();
    endtask

    task automatic extract(input int d);
        hb.delete(); hc.delete(); her.delete(); hsp.delete(); huf.delete();
        foreach (lg[i]) begin
            if (lg[i].d == d && lg[i].en === 1'b1) begin
                hb.push_back(lg[i].txd); hc.push_back(lg[i].cyc);
                her.push_back(lg[i].er); hsp.push_back(lg[i].sp); huf.push_back(lg[i].uf);
            end
        end
    endtask

    // Bit-serial reference FCS over mdl.
    function automatic logic [31:0] fcs_ref();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (mdl[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ mdl[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    task automatic build_exp(input int n, input logic [7:0] first, input int padto);
        logic [31:0] f;
        exp_q.delete(); mdl.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 0; i < n; i++) mdl.push_back(8'(first + i));
        while (mdl.size() < padto) mdl.push_back(8'h00);
        foreach (mdl[i]) exp_q.push_back(mdl[i]);
        f = fcs_ref();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(f >> (8 * i)));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tdata[k] = 8'h00; tvalid[k] = 1'b0; tlast[k] = 1'b0; tuser[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if ({txd[k], en[k], er[k], sp[k], uf[k], tready[k]} !== 13'h0) begin
                fails++;
                $display("[TB] FAIL reset_outputs dut%0d: got %h required 0000", k,
                         {txd[k], en[k], er[k], sp[k], uf[k], tready[k]});
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] ref_q[$];
        int sp_pos;
        int lows;
        lg.delete();
        add_frame(9, 8'h31, 1'b0);
        drive_beats(0, -1, 0);
        repeat (30) @(negedge clk);
        extract(0);
        for (int i = 0; i < 7; i++) ref_q.push_back(8'h55);
        ref_q.push_back(8'hD5);
        for (int i = 0; i < 9; i++) ref_q.push_back(8'(8'h31 + i));
        ref_q.push_back(8'h26); ref_q.push_back(8'h39); ref_q.push_back(8'hF4); ref_q.push_back(8'hCB);
        tests++;
        if (hb.size() != 21) begin
            fails++;
            $display("[TB] FAIL basic_len: got %0d tx_en cycles required 21", hb.size());
        end
        for (int i = 0; i < 21; i++) begin
            tests++;
            if (i >= hb.size() || hb[i] !== ref_q[i]) begin
                fails++;
                $display("[TB] FAIL basic_byte[%0d]: got %h required %h", i,
                         (i < hb.size()) ? hb[i] : 8'hxx, ref_q[i]);
            end
        end
        if (hb.size() == 21) begin
            tests++;
            if (hc[20] - hc[0] != 20) begin
                fails++;
                $display("[TB] FAIL basic_contig: got span %0d required 20", hc[20] - hc[0]);
            end
            lows = 0;
            foreach (lg[i]) if (lg[i].d == 0 && lg[i].cyc > hc[20] && lg[i].cyc <= hc[20] + 12 && lg[i].en === 1'b0) lows++;
            tests++;
            if (lows != 12) begin
                fails++;
                $display("[TB] FAIL basic_ifg: got %0d low cycles required 12", lows);
            end
        end
        sp_pos = -1;
        foreach (hsp[i]) if (hsp[i] === 1'b1) sp_pos = (sp_pos == -1) ? i : -2;
        tests++;
        if (sp_pos != 7) begin
            fails++;
            $display("[TB] FAIL basic_start_packet: got position %0d required 7", sp_pos);
        end
    endtask

    task automatic test_padding();
        lg.delete();
        add_frame(10, 8'h01, 1'b0);
        drive_beats(1, -1, 0);
        repeat (90) @(negedge clk);
        extract(1);
        build_exp(10, 8'h01, 60);
        tests++;
        if (hb.size() != 72) begin
            fails++;
            $display("[TB] FAIL pad_len: got %0d tx_en cycles required 72", hb.size());
        end
        for (int i = 0; i < 72; i++) begin
            tests++;
            if (i >= hb.size() || hb[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL pad_byte[%0d]: got %h required %h", i,
                         (i < hb.size()) ? hb[i] : 8'hxx, exp_q[i]);
            end
        end
        if (hb.size() == 72) begin
            tests++;
            if (hc[71] - hc[0] != 71) begin
                fails++;
                $display("[TB] FAIL pad_contig: got span %0d required 71", hc[71] - hc[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        lg.delete();
        add_frame(64, 8'h00, 1'b0);
        add_frame(64, 8'h80, 1'b0);
        drive_beats(1, -1, 0);
        repeat (40) @(negedge clk);
        extract(1);
        tests++;
        if (hb.size() != 152) begin
            fails++;
            $display("[TB] FAIL b2b_len: got %0d tx_en cycles required 152", hb.size());
        end
        for (int f = 0; f < 2; f++) begin
            build_exp(64, (f == 0) ? 8'h00 : 8'h80, 60);
            for (int i = 0; i < 76; i++) begin
                tests++;
                if (f * 76 + i >= hb.size() || hb[f * 76 + i] !== exp_q[i]) begin
                    fails++;
                    $display("[TB] FAIL b2b_byte[%0d][%0d]: got %h required %h", f, i,
                             (f * 76 + i < hb.size()) ? hb[f * 76 + i] : 8'hxx, exp_q[i]);
                end
            end
        end
        if (hb.size() == 152) begin
            tests++;
            if (hc[76] - hc[75] != 13) begin
                fails++;
                $display("[TB] FAIL b2b_gap: got %0d cycles required 13", hc[76] - hc[75]);
            end
        end
    endtask

    task automatic test_underflow();
        int er_cnt;
        int uf_cnt;
        lg.delete();
        add_frame(8, 8'hA0, 1'b0);
        add_frame(3, 8'h10, 1'b0);
        drive_beats(1, 5, 1);
        repeat (100) @(negedge clk);
        extract(1);
        tests++;
        if (hb.size() != 86) begin
            fails++;
            $display("[TB] FAIL uf_len: got %0d tx_en cycles required 86", hb.size());
        end
        build_exp(5, 8'hA0, 0);
        exp_q[13] = 8'h00;
        for (int i = 0; i < 14; i++) begin
            tests++;
            if (i >= hb.size() || hb[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL uf_byte[%0d]: got %h required %h", i,
                         (i < hb.size()) ? hb[i] : 8'hxx, exp_q[i]);
            end
        end
        er_cnt = 0; uf_cnt = 0;
        foreach (lg[i]) if (lg[i].d == 1) begin
            if (lg[i].er === 1'b1) er_cnt++;
            if (lg[i].uf === 1'b1) uf_cnt++;
        end
        tests++;
        if (er_cnt != 1 || uf_cnt != 1 || huf.size() < 14 || huf[13] !== 1'b1 || her[13] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL uf_flags: got er=%0d uf=%0d pulses required one each on cycle 13", er_cnt, uf_cnt);
        end
        if (hb.size() == 86) begin
            tests++;
            if (hc[13] - hc[0] != 13 || hc[14] - hc[13] != 16) begin
                fails++;
                $display("[TB] FAIL uf_timing: got spans %0d/%0d required 13/16", hc[13] - hc[0], hc[14] - hc[13]);
            end
            build_exp(3, 8'h10, 60);
            for (int i = 0; i < 72; i++) begin
                tests++;
                if (hb[14 + i] !== exp_q[i]) begin
                    fails++;
                    $display("[TB] FAIL uf_next_byte[%0d]: got %h required %h", i, hb[14 + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_tuser();
        int er_cnt;
        lg.delete();
        add_frame(20, 8'h40, 1'b1);
        drive_beats(1, -1, 0);
        repeat (90) @(negedge clk);
        extract(1);
        build_exp(20, 8'h40, 60);
        tests++;
        if (hb.size() != 72) begin
            fails++;
            $display("[TB] FAIL tuser_len: got %0d tx_en cycles required 72", hb.size());
        end
        for (int i = 0; i < 72; i++) begin
            tests++;
            if (i >= hb.size() || hb[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL tuser_byte[%0d]: got %h required %h", i,
                         (i < hb.size()) ? hb[i] : 8'hxx, exp_q[i]);
            end
        end
        er_cnt = 0;
        foreach (lg[i]) if (lg[i].d == 1 && lg[i].er === 1'b1) er_cnt++;
        tests++;
        if (er_cnt != 1 || her.size() < 28 || her[27] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL tuser_er: got %0d tx_er cycles required exactly one at position 27", er_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic was_en;
        lg.delete();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            tvalid[1] = 1'b1; tdata[1] = 8'(i); tlast[1] = 1'b0;
        end
        @(negedge clk);
        was_en = en[1];
        #2 rst = 1'b1;
        #1;
        tests++;
        if (was_en !== 1'b1 || {txd[1], en[1], er[1], sp[1], uf[1]} !== 12'h0) begin
            fails++;
            $display("[TB] FAIL reset_mid_async: got en_before=%b outputs=%h required 1 and 000",
                     was_en, {txd[1], en[1], er[1], sp[1], uf[1]});
        end
        tvalid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        lg.delete();
        add_frame(3, 8'h20, 1'b0);
        drive_beats(1, -1, 0);
        repeat (90) @(negedge clk);
        extract(1);
        build_exp(3, 8'h20, 60);
        tests++;
        if (hb.size() != 72) begin
            fails++;
            $display("[TB] FAIL reset_mid_len: got %0d tx_en cycles required 72", hb.size());
        end
        for (int i = 0; i < 72; i++) begin
            tests++;
            if (i >= hb.size() || hb[i] !== exp_q[i]) begin
                fails++;
                $display("[TB] FAIL reset_mid_byte[%0d]: got %h required %h", i,
                         (i < hb.size()) ? hb[i] : 8'hxx, exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_padding();
        test_back_to_back();
        test_underflow();
        test_tuser();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
